// File: rtl/buzzer_pkg.sv
// Shared types and default constants for the buzzer tone mixer.
// Holds the tone FSM state type, the channel count limit and default channel tables.
package buzzer_pkg;

    localparam int MAX_CH = 8;

    // Default per-channel sound lengths and tone half-periods (game_clk cycles).
    localparam logic [5:0] DEF_DUR_CH0 = 6'd31;
    localparam logic [5:0] DEF_DUR_CH1 = 6'd63;
    localparam logic [7:0] DEF_HP_CH0  = 8'd4;
    localparam logic [7:0] DEF_HP_CH1  = 8'd8;

    typedef enum logic {
        IDLE,
        PLAY
    } tone_state_t;

endpackage

// File: rtl/buzzer_channel_timer.sv
// One event channel: reloadable duration counter with a registered active flag.
// active_next exposes the flag's next value so the mixer can react on the same edge.
module buzzer_channel_timer
    import buzzer_pkg::*;
#(
    parameter int               DUR_W    = 6,
    parameter logic [DUR_W-1:0] DURATION = DEF_DUR_CH0
) (
    input  logic game_clk,
    input  logic game_rst_n,
    input  logic trig,
    output logic active_next,
    output logic active
);

    logic [DUR_W-1:0] cnt_reg;
    logic [DUR_W-1:0] cnt_next;
    logic             active_reg;

    // A trigger always wins over expiry, so a retrigger on the last cycle extends seamlessly.
    always_comb begin
        cnt_next    = cnt_reg;
        active_next = active_reg;
        if (trig && (DURATION != '0)) begin
            cnt_next    = DURATION;
            active_next = 1'b1;
        end else if (active_reg) begin
            if (cnt_reg == DUR_W'(1)) begin
                cnt_next    = '0;
                active_next = 1'b0;
            end else begin
                cnt_next = cnt_reg - DUR_W'(1);
            end
        end
    end

    always_ff @(posedge game_clk or negedge game_rst_n) begin
        if (!game_rst_n) begin
            cnt_reg    <= '0;
            active_reg <= 1'b0;
        end else begin
            cnt_reg    <= cnt_next;
            active_reg <= active_next;
        end
    end

    assign active = active_reg;

endmodule

// File: rtl/buzzer_tone_mixer.sv
// Multi-channel buzzer: per-channel timers, lowest-index priority select and a
// square-wave divider driven by a two-state tone FSM. All outputs are registered.
module buzzer_tone_mixer
    import buzzer_pkg::*;
#(
    parameter int                      NUM_CH         = 2,
    parameter int                      DUR_W          = 6,
    parameter int                      DIV_W          = 8,
    parameter logic [NUM_CH*DUR_W-1:0] CH_DURATION    = {DEF_DUR_CH0, DEF_DUR_CH1},
    parameter logic [NUM_CH*DIV_W-1:0] CH_HALF_PERIOD = {DEF_HP_CH0, DEF_HP_CH1},
    localparam int                     AW             = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              game_clk,
    input  logic              game_rst_n,
    input  logic [NUM_CH-1:0] trig,
    input  logic              mute,
    output logic              buzzer,
    output logic              busy,
    output logic [NUM_CH-1:0] ch_active,
    output logic [AW-1:0]     active_ch
);

    // Channel tables are listed leftmost-first: channel 0 occupies the top slice.
    logic [NUM_CH-1:0] act_next;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            buzzer_channel_timer #(
                .DUR_W    (DUR_W),
                .DURATION (CH_DURATION[(NUM_CH-1-gi)*DUR_W +: DUR_W])
            ) u_timer (
                .game_clk    (game_clk),
                .game_rst_n  (game_rst_n),
                .trig        (trig[gi]),
                .active_next (act_next[gi]),
                .active      (ch_active[gi])
            );
        end
    endgenerate

    tone_state_t      state_reg;
    tone_state_t      state_next;
    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] div_next;
    logic             tone_reg;
    logic             tone_next;
    logic             buzzer_reg;
    logic             busy_reg;
    logic [AW-1:0]    active_ch_reg;
    logic [AW-1:0]    winner_next;
    logic [DIV_W-1:0] half_sel;
    logic             any_next;

    assign any_next = |act_next;

    always_comb begin
        winner_next = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (act_next[i]) begin
                winner_next = AW'(i);
            end
        end
    end

    always_comb begin
        half_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (winner_next == AW'(i)) begin
                half_sel = CH_HALF_PERIOD[(NUM_CH-1-i)*DIV_W +: DIV_W];
            end
        end
        if (half_sel == '0) begin
            half_sel = DIV_W'(1);
        end
    end

    // A new winner restarts the waveform low; the same winner keeps its phase.
    always_comb begin
        state_next = state_reg;
        div_next   = div_reg;
        tone_next  = tone_reg;
        case (state_reg)
            IDLE: begin
                div_next  = '0;
                tone_next = 1'b0;
                if (any_next) begin
                    state_next = PLAY;
                end
            end
            PLAY: begin
                if (!any_next) begin
                    state_next = IDLE;
                    div_next   = '0;
                    tone_next  = 1'b0;
                end else if (winner_next != active_ch_reg) begin
                    div_next  = '0;
                    tone_next = 1'b0;
                end else if (div_reg == (half_sel - DIV_W'(1))) begin
                    div_next  = '0;
                    tone_next = ~tone_reg;
                end else begin
                    div_next = div_reg + DIV_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                div_next   = '0;
                tone_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge game_clk or negedge game_rst_n) begin
        if (!game_rst_n) begin
            state_reg     <= IDLE;
            div_reg       <= '0;
            tone_reg      <= 1'b0;
            buzzer_reg    <= 1'b0;
            busy_reg      <= 1'b0;
            active_ch_reg <= '0;
        end else begin
            state_reg     <= state_next;
            div_reg       <= div_next;
            tone_reg      <= tone_next;
            buzzer_reg    <= tone_next & ~mute;
            busy_reg      <= any_next;
            active_ch_reg <= winner_next;
        end
    end

    assign buzzer    = buzzer_reg;
    assign busy      = busy_reg;
    assign active_ch = active_ch_reg;

endmodule

// File: tb/tb_buzzer_tone_mixer.sv
// Directed bench for buzzer_tone_mixer with default parameters (ch0: 31 cycles/H=4, ch1: 63 cycles/H=8).
// "Cycle k" is the state registered at the k-th rising edge after reset release.
module tb_buzzer_tone_mixer;

    logic       game_clk   = 1'b0;
    logic       game_rst_n = 1'b0;
    logic [1:0] trig       = 2'b00;
    logic       mute       = 1'b0;
    logic       buzzer;
    logic       busy;
    logic [1:0] ch_active;
    logic [0:0] active_ch;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;

    always #5 game_clk = ~game_clk;

    buzzer_tone_mixer dut (
        .game_clk   (game_clk),
        .game_rst_n (game_rst_n),
        .trig       (trig),
        .mute       (mute),
        .buzzer     (buzzer),
        .busy       (busy),
        .ch_active  (ch_active),
        .active_ch  (active_ch)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string sc, input logic [1:0] ea, input int eac, input logic ebz);
        check_val($sformatf("%s.ch_active@%0d", sc, cyc), 32'(ch_active), 32'(ea));
        check_val($sformatf("%s.busy@%0d", sc, cyc), 32'(busy), 32'(ea != 2'b00));
        check_val($sformatf("%s.active_ch@%0d", sc, cyc), 32'(active_ch), 32'(eac));
        check_val($sformatf("%s.buzzer@%0d", sc, cyc), 32'(buzzer), 32'(ebz));
    endtask

    task automatic step(input logic [1:0] t, input logic m);
        trig = t;
        mute = m;
        @(posedge game_clk);
        #1;
        trig = 2'b00;
        mute = 1'b0;
        cyc++;
    endtask

    task automatic do_reset();
        game_rst_n = 1'b0;
        trig       = 2'b00;
        mute       = 1'b0;
        repeat (2) @(posedge game_clk);
        @(negedge game_clk);
        game_rst_n = 1'b1;
        cyc        = 0;
    endtask

    // Square-wave level k cycles into a segment that started low at cycle s.
    function automatic logic ph(input int k, input int s, input int h);
        return (((k - s) / h) % 2) == 1;
    endfunction

    initial begin
        logic [1:0] ea;
        logic       bz;
        int         ac;

        // A: single ch1 event, 63 cycles, period 16
        do_reset();
        check_all("RST", 2'b00, 0, 1'b0);
        for (int k = 1; k <= 80; k++) begin
            step((k == 10) ? 2'b10 : 2'b00, 1'b0);
            ea = {(k >= 10 && k <= 72), 1'b0};
            check_all("A", ea, ea[1] ? 1 : 0, ea[1] && ph(k, 10, 8));
        end
        $display("scenario A: ch1 single event, %0d compared so far", n_cmp);

        // B: ch0 pre-empts ch1, then ch1 resumes with a fresh divider
        do_reset();
        for (int k = 1; k <= 80; k++) begin
            step((k == 10) ? 2'b10 : ((k == 20) ? 2'b01 : 2'b00), 1'b0);
            ea = {(k >= 10 && k <= 72), (k >= 20 && k <= 50)};
            if (ea[0]) begin
                ac = 0;
                bz = ph(k, 20, 4);
            end else if (ea[1]) begin
                ac = 1;
                bz = (k < 20) ? ph(k, 10, 8) : ph(k, 51, 8);
            end else begin
                ac = 0;
                bz = 1'b0;
            end
            check_all("B", ea, ac, bz);
        end
        $display("scenario B: priority switch, %0d compared so far", n_cmp);

        // C: retrigger of the current winner keeps phase
        do_reset();
        for (int k = 1; k <= 80; k++) begin
            step((k == 10 || k == 40) ? 2'b01 : 2'b00, 1'b0);
            ea = {1'b0, (k >= 10 && k <= 70)};
            check_all("C", ea, 0, ea[0] && ph(k, 10, 4));
        end
        $display("scenario C: retrigger, %0d compared so far", n_cmp);

        // D: retrigger exactly on the expiry edge
        do_reset();
        for (int k = 1; k <= 80; k++) begin
            step((k == 10 || k == 41) ? 2'b01 : 2'b00, 1'b0);
            ea = {1'b0, (k >= 10 && k <= 71)};
            check_all("D", ea, 0, ea[0] && ph(k, 10, 4));
        end
        $display("scenario D: expiry retrigger, %0d compared so far", n_cmp);

        // E: mute window leaves timers and divider phase untouched
        do_reset();
        for (int k = 1; k <= 50; k++) begin
            step((k == 10) ? 2'b01 : 2'b00, (k >= 15 && k <= 25));
            ea = {1'b0, (k >= 10 && k <= 40)};
            check_all("E", ea, 0, ea[0] && ph(k, 10, 4) && !(k >= 15 && k <= 25));
        end
        $display("scenario E: mute, %0d compared so far", n_cmp);

        // F: asynchronous reset mid-tone, triggers ignored during reset
        do_reset();
        for (int k = 1; k <= 30; k++) begin
            step((k == 10) ? 2'b10 : 2'b00, 1'b0);
            ea = {(k >= 10), 1'b0};
            check_all("F", ea, ea[1] ? 1 : 0, ea[1] && ph(k, 10, 8));
        end
        #2;
        game_rst_n = 1'b0;
        #1;
        check_all("F.async", 2'b00, 0, 1'b0);
        for (int r = 0; r < 3; r++) begin
            trig = 2'b11;
            @(posedge game_clk);
            #1;
            check_all("F.inrst", 2'b00, 0, 1'b0);
        end
        trig = 2'b00;
        @(negedge game_clk);
        game_rst_n = 1'b1;
        cyc        = 0;
        for (int k = 1; k <= 40; k++) begin
            step((k == 5) ? 2'b01 : 2'b00, 1'b0);
            ea = {1'b0, (k >= 5 && k <= 35)};
            check_all("F.post", ea, 0, ea[0] && ph(k, 5, 4));
        end
        $display("scenario F: async reset, %0d compared so far", n_cmp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/buzzer_tone_mixer.md
BUZZER_TONE_MIXER -- requirements
Module: buzzer_tone_mixer

Interface
REQ-001 Parameter NUM_CH, default 2: number of independent event channels (1..8).
REQ-002 Parameter DUR_W, default 6: width of each channel duration counter.
REQ-003 Parameter DIV_W, default 8: width of the tone half-period divider.
REQ-004 Parameter CH_DURATION, default {6'd31, 6'd63}: packed NUM_CH x DUR_W; entry i is channel i's sound length in game_clk cycles; 0 disables the channel.
REQ-005 Parameter CH_HALF_PERIOD, default {8'd4, 8'd8}: packed NUM_CH x DIV_W; entry i is channel i's tone half-period in game_clk cycles; 0 is treated as 1.
REQ-006 game_clk  input  1  sole clock; all state changes on the rising edge.
REQ-007 game_rst_n  input  1  asynchronous, active-low reset.
REQ-008 trig  input  NUM_CH  per-channel single-cycle collision pulse; bit i starts or restarts channel i.
REQ-009 mute  input  1  forces buzzer low; timers keep running.
REQ-010 buzzer  output  1  registered square-wave drive.
REQ-011 busy  output  1  high while any channel is active.
REQ-012 ch_active  output  NUM_CH  per-channel active flags, registered.
REQ-013 active_ch  output  $clog2(NUM_CH) (min 1)  index of the channel currently driving the tone; 0 when idle.

Function
REQ-014 Trigger on channel i sampled at edge N with CH_DURATION[i] = D > 0 shall set ch_active[i] from edge N and hold it exactly D cycles; ch_active[i] falls at edge N+D.
REQ-015 A trigger on a channel whose CH_DURATION is 0 shall be ignored.
REQ-016 A trigger on an already-active channel shall reload its counter to the full D; no cycle gap in ch_active.
REQ-017 A trigger coinciding with the expiry cycle shall win: the channel stays active for a fresh D cycles.
REQ-018 Simultaneous triggers on several channels shall start every triggered channel independently in the same cycle.
REQ-019 Priority: the lowest-index active channel owns the tone; active_ch = that index.
REQ-020 Tone FSM states IDLE and PLAY; IDLE->PLAY when any ch_active becomes 1; PLAY->IDLE when all ch_active are 0.
REQ-021 On entry to PLAY, and whenever the winning channel changes, the divider shall clear and buzzer shall go low at that edge.
REQ-022 In PLAY, buzzer shall toggle every H cycles, H = CH_HALF_PERIOD[active_ch]: low H cycles, high H cycles, repeating.
REQ-023 Retrigger of the current winner shall not restart the divider (phase continuous).
REQ-024 In IDLE, buzzer = 0 and the divider holds 0.
REQ-025 mute = 1 shall force buzzer to 0 at the next edge without altering divider phase, ch_active or busy; releasing mute resumes the running phase.
REQ-026 busy = OR of ch_active; all outputs registered, no combinational path from inputs to outputs.
REQ-027 Duration and divider counters shall saturate-compare with ==, never wrap through zero while active.

Reset
REQ-028 game_rst_n low shall asynchronously force buzzer = 0, busy = 0, ch_active = 0, active_ch = 0, all counters to 0, FSM to IDLE.
REQ-029 Reset asserted mid-tone shall abort all channels; triggers are ignored while reset is low; first trigger after release behaves per REQ-014.

Structure
REQ-030 Package buzzer_pkg shall hold the tone FSM state typedef, default duration/half-period constants, and the channel count limit.
REQ-031 Sub-module buzzer_channel_timer (one per channel, generate loop) shall contain the duration counter and ch_active flag; the top holds priority select, divider and FSM.

Verification
REQ-032 Defaults; trig[1] pulse at cycle 10 -> ch_active[1] high cycles 10..72 (63 cycles), buzzer period 16 cycles starting low, buzzer 0 and busy 0 from cycle 73.
REQ-033 trig[1] at 10, trig[0] at 20 -> active_ch switches 1->0 at 20, buzzer low at 20 then period 8; after channel 0 ends (cycle 51) active_ch returns to 1 with divider restarted.
REQ-034 trig[0] at 10 and again at 40 -> ch_active[0] continuous until cycle 71, no buzzer phase glitch at 40.
REQ-035 trig[0] exactly on its expiry cycle -> ch_active[0] never drops; 31 further cycles.
REQ-036 mute high cycles 15..25 during channel-0 tone -> buzzer 0 there, phase at 26 matches unmuted reference model.
REQ-037 game_rst_n low at cycle 30 of an active tone -> all outputs 0 immediately (asynchronous), trig during reset ignored.
